// File: rtl/any1_pkg.sv
// Shared ANY-1 register-file constants and the writeback request payload.
// Imported by the regfile and by the writeback arbiter.
package any1_pkg;

  localparam int REG_ADDR_W = 10;
  localparam int REG_DATA_W = 80;

  typedef struct packed {
    logic [9:0]  wa;
    logic [79:0] data;
  } any1_wb_req_t;

  // Round-robin successor of idx among n slots.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/any1_wb_arbiter_if.sv
// Result-source handshake bundle plus the regfile write port of the writeback arbiter.
// The slave modport is the arbiter's view.
interface any1_wb_arbiter_if #(
  parameter int NSRC = 3,
  parameter int AW   = any1_pkg::REG_ADDR_W,
  parameter int DW   = any1_pkg::REG_DATA_W
);
  logic [NSRC-1:0]    s_valid;
  logic [NSRC-1:0]    s_ready;
  logic [NSRC*AW-1:0] s_wa;
  logic [NSRC*DW-1:0] s_data;
  logic               wr;
  logic [AW-1:0]      wa;
  logic [DW-1:0]      i;
  logic               idle;

  modport master (
    output s_valid, s_wa, s_data,
    input  s_ready, wr, wa, i, idle
  );

  modport slave (
    input  s_valid, s_wa, s_data,
    output s_ready, wr, wa, i, idle
  );
endinterface

// File: rtl/any1_wb_arbiter_fifo.sv
// Per-source circular queue of writeback requests; no bypass around an empty queue.
module any1_wb_fifo
  import any1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  any1_wb_req_t                 din,
  input  logic                         pop,
  output any1_wb_req_t                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  any1_wb_req_t  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/any1_wb_arbiter.sv
// Round-robin writeback arbiter merging NSRC result queues onto the single regfile write port.
// Writes to register 0 of any bank are consumed but never raise wr.
module any1_wb_arbiter
  import any1_pkg::*;
#(
  parameter int NSRC  = 3,
  parameter int DEPTH = 2,
  parameter int AW    = REG_ADDR_W,
  parameter int DW    = REG_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  any1_wb_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(NSRC);
  localparam int CW    = $clog2(DEPTH + 1);

  any1_wb_req_t     din_s   [NSRC];
  any1_wb_req_t     dout_s  [NSRC];
  logic [CW-1:0]    count_s [NSRC];
  logic [NSRC-1:0]  full_s;
  logic [NSRC-1:0]  empty_s;
  logic [NSRC-1:0]  pop_s;
  logic             grant_vld_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic [PTR_W-1:0] search_idx_s;
  any1_wb_req_t     sel_s;
  logic             idle_s;

  logic [PTR_W-1:0] rr_ptr_r;
  logic             wr_r;
  logic [AW-1:0]    wa_r;
  logic [DW-1:0]    i_r;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign din_s[k] = {bus.s_wa[k*AW +: AW], bus.s_data[k*DW +: DW]};
    assign pop_s[k] = grant_vld_s && (grant_idx_s == PTR_W'(k));

    any1_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.s_valid[k]),
      .din   (din_s[k]),
      .pop   (pop_s[k]),
      .dout  (dout_s[k]),
      .full  (full_s[k]),
      .empty (empty_s[k]),
      .count (count_s[k])
    );
  end

  // First non-empty queue at or after rr_ptr, wrapping modulo NSRC.
  always_comb begin
    grant_vld_s  = 1'b0;
    grant_idx_s  = {PTR_W{1'b0}};
    search_idx_s = rr_ptr_r;
    for (int j = 0; j < NSRC; j++) begin
      if (!grant_vld_s && !empty_s[search_idx_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = search_idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
      search_idx_s = PTR_W'(wrap_inc(int'(search_idx_s), NSRC));
    end
  end

  assign sel_s = dout_s[grant_idx_s];

  // Idle needs every queue drained and no write still on the port.
  always_comb begin
    idle_s = !wr_r;
    for (int k = 0; k < NSRC; k++) begin
      idle_s = idle_s && (count_s[k] == {CW{1'b0}});
    end
  end

  // Output register and round-robin pointer; wa/i hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r     <= 1'b0;
      wa_r     <= {AW{1'b0}};
      i_r      <= {DW{1'b0}};
      rr_ptr_r <= {PTR_W{1'b0}};
    end else if (grant_vld_s) begin
      wr_r     <= (sel_s.wa[5:0] != 6'd0);
      wa_r     <= sel_s.wa;
      i_r      <= sel_s.data;
      rr_ptr_r <= PTR_W'(wrap_inc(int'(grant_idx_s), NSRC));
    end else begin
      wr_r     <= 1'b0;
    end
  end

  assign bus.s_ready = ~full_s;
  assign bus.wr      = wr_r;
  assign bus.wa      = wa_r;
  assign bus.i       = i_r;
  assign bus.idle    = idle_s;

endmodule

// File: tb/tb_any1_wb_arbiter.sv
// Directed bench for any1_wb_arbiter: vector table for single write, r0 sink and
// round-robin streaming, plus hand sequences for backpressure and mid-stream reset.
module tb_any1_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  any1_wb_arbiter_if #(.NSRC(3), .AW(10), .DW(80)) bus ();

  any1_wb_arbiter #(.NSRC(3), .DEPTH(2), .AW(10), .DW(80)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   valid;
    logic [29:0]  wa;
    logic [239:0] data;
    logic         exp_wr;
    logic [9:0]   exp_wa;
    logic [79:0]  exp_i;
    logic [2:0]   exp_ready;
    logic         exp_idle;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [2:0] v,
                              input logic [9:0] w0, input logic [9:0] w1, input logic [9:0] w2,
                              input logic [79:0] d0, input logic [79:0] d1, input logic [79:0] d2,
                              input logic ewr, input logic [9:0] ewa, input logic [79:0] ei,
                              input logic [2:0] erdy, input logic eidl);
    vec_t r;
    r.valid = v;
    r.wa = {w2, w1, w0};
    r.data = {d2, d1, d0};
    r.exp_wr = ewr;
    r.exp_wa = ewa;
    r.exp_i = ei;
    r.exp_ready = erdy;
    r.exp_idle = eidl;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int idx, input logic ewr, input logic [9:0] ewa,
                               input logic [79:0] ei, input logic [2:0] erdy, input logic eidl);
    check({tag, "_wr"}, idx, 80'(bus.wr), 80'(ewr));
    check({tag, "_wa"}, idx, 80'(bus.wa), 80'(ewa));
    check({tag, "_i"}, idx, bus.i, ei);
    check({tag, "_ready"}, idx, 80'(bus.s_ready), 80'(erdy));
    check({tag, "_idle"}, idx, 80'(bus.idle), 80'(eidl));
  endtask

  logic [9:0]  log0 [$];
  logic [9:0]  log1 [$];
  logic [9:0]  log2 [$];
  logic [9:0]  w0, w1, w2;
  logic [2:0]  hs;
  int          n0, n1, n2, nw, cyc;
  bit          saw_bp;

  initial begin
    bus.s_valid = 3'b000;
    bus.s_wa    = 30'd0;
    bus.s_data  = 240'd0;

    // vectors: single write latency, register-zero sink, round-robin streaming
    vecs[0]  = mk(3'b010, 10'h000, 10'h045, 10'h000, 80'h0, 80'h1234, 80'h0, 1'b0, 10'h000, 80'h0,    3'b111, 1'b0);
    vecs[1]  = mk(3'b000, 10'h000, 10'h045, 10'h000, 80'h0, 80'h1234, 80'h0, 1'b1, 10'h045, 80'h1234, 3'b111, 1'b0);
    vecs[2]  = mk(3'b000, 10'h000, 10'h045, 10'h000, 80'h0, 80'h1234, 80'h0, 1'b0, 10'h045, 80'h1234, 3'b111, 1'b1);
    vecs[3]  = mk(3'b100, 10'h000, 10'h000, 10'h040, 80'h0, 80'h0, 80'hFF,    1'b0, 10'h045, 80'h1234, 3'b111, 1'b0);
    vecs[4]  = mk(3'b000, 10'h000, 10'h000, 10'h040, 80'h0, 80'h0, 80'hFF,    1'b0, 10'h040, 80'hFF,   3'b111, 1'b1);
    vecs[5]  = mk(3'b000, 10'h000, 10'h000, 10'h040, 80'h0, 80'h0, 80'hFF,    1'b0, 10'h040, 80'hFF,   3'b111, 1'b1);
    vecs[6]  = mk(3'b111, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b0, 10'h040, 80'hFF,   3'b111, 1'b0);
    vecs[7]  = mk(3'b111, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h001, 80'hA1,   3'b001, 1'b0);
    vecs[8]  = mk(3'b111, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h002, 80'hA2,   3'b010, 1'b0);
    vecs[9]  = mk(3'b111, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h003, 80'hA3,   3'b100, 1'b0);
    vecs[10] = mk(3'b111, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h001, 80'hA1,   3'b001, 1'b0);
    vecs[11] = mk(3'b111, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h002, 80'hA2,   3'b010, 1'b0);
    vecs[12] = mk(3'b111, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h003, 80'hA3,   3'b100, 1'b0);
    vecs[13] = mk(3'b000, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h001, 80'hA1,   3'b101, 1'b0);
    vecs[14] = mk(3'b000, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h002, 80'hA2,   3'b111, 1'b0);
    vecs[15] = mk(3'b000, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h003, 80'hA3,   3'b111, 1'b0);
    vecs[16] = mk(3'b000, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h001, 80'hA1,   3'b111, 1'b0);
    vecs[17] = mk(3'b000, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b1, 10'h002, 80'hA2,   3'b111, 1'b0);
    vecs[18] = mk(3'b000, 10'h001, 10'h002, 10'h003, 80'hA1, 80'hA2, 80'hA3, 1'b0, 10'h002, 80'hA2,   3'b111, 1'b1);

    // reset held for three cycles, then released
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_outputs("reset", c, 1'b0, 10'h000, 80'h0, 3'b111, 1'b1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_reset", 0, 1'b0, 10'h000, 80'h0, 3'b111, 1'b1);

    for (int v = 0; v < NVEC; v++) begin
      bus.s_valid = vecs[v].valid;
      bus.s_wa    = vecs[v].wa;
      bus.s_data  = vecs[v].data;
      @(posedge clk); #1;
      check_outputs("vec", v, vecs[v].exp_wr, vecs[v].exp_wa, vecs[v].exp_i,
                    vecs[v].exp_ready, vecs[v].exp_idle);
    end

    // backpressure: source 0 offers 3 entries while sources 1 and 2 stream 4 each
    n0 = 0; n1 = 0; n2 = 0; nw = 0; cyc = 0; saw_bp = 1'b0;
    while ((n0 < 3 || n1 < 4 || n2 < 4 || nw < 11) && cyc < 60) begin
      w0 = 10'h011 + 10'(n0);
      w1 = 10'h021 + 10'(n1);
      w2 = 10'h031 + 10'(n2);
      bus.s_valid = {(n2 < 4), (n1 < 4), (n0 < 3)};
      bus.s_wa    = {w2, w1, w0};
      bus.s_data  = {80'(w2) + 80'h1000, 80'(w1) + 80'h1000, 80'(w0) + 80'h1000};
      if (bus.s_valid[0] && !bus.s_ready[0]) saw_bp = 1'b1;
      hs = bus.s_valid & bus.s_ready;
      @(posedge clk); #1;
      n0 += int'(hs[0]);
      n1 += int'(hs[1]);
      n2 += int'(hs[2]);
      if (bus.wr) begin
        nw++;
        check("bp_data", nw, bus.i, 80'(bus.wa) + 80'h1000);
        case (bus.wa[9:4])
          6'h01:   log0.push_back(bus.wa);
          6'h02:   log1.push_back(bus.wa);
          6'h03:   log2.push_back(bus.wa);
          default: log0.push_back(10'h3FF);
        endcase
      end
      cyc++;
    end
    bus.s_valid = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.wr) nw++;
    end
    check("bp_seen", 0, 80'(saw_bp), 80'd1);
    check("bp_total_writes", 0, 80'(nw), 80'd11);
    check("bp_src0_count", 0, 80'(log0.size()), 80'd3);
    check("bp_src1_count", 0, 80'(log1.size()), 80'd4);
    check("bp_src2_count", 0, 80'(log2.size()), 80'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < 3) check("bp_src0_order", j, 80'((j < log0.size()) ? log0[j] : 10'h3FF), 80'(10'h011 + 10'(j)));
      check("bp_src1_order", j, 80'((j < log1.size()) ? log1[j] : 10'h3FF), 80'(10'h021 + 10'(j)));
      check("bp_src2_order", j, 80'((j < log2.size()) ? log2[j] : 10'h3FF), 80'(10'h031 + 10'(j)));
    end
    check("bp_idle", 0, 80'(bus.idle), 80'd1);

    // reset mid-stream: queue entries, start writing, then drop rst_n between edges
    bus.s_valid = 3'b111;
    bus.s_wa    = {10'h053, 10'h052, 10'h051};
    bus.s_data  = {80'hC3, 80'hC2, 80'hC1};
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.s_valid = 3'b000;
    check("mid_wr_before", 0, 80'(bus.wr), 80'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs("mid_reset", 0, 1'b0, 10'h000, 80'h0, 3'b111, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("after_reset_wr", c, 80'(bus.wr), 80'd0);
      check("after_reset_idle", c, 80'(bus.idle), 80'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
